// File: rtl/delay_line_sched.sv
// delay_line_sched: valid/ready sequencer for an enable-gated tap delay line with fill tracking and zero-flush
module delay_line_sched #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              flush_req,
  output logic              shift_en,
  output logic [DATA_W-1:0] shift_data,
  output logic [CNT_W-1:0]  fill_cnt,
  output logic              line_full,
  output logic              tap_valid,
  output logic              busy
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  logic [0:0] state;
  logic [CNT_W-1:0] flush_cnt;
  logic sample_shift;
  assign s_ready = state == IDLE && !flush_req;
  assign busy = state == FLUSH;
  assign line_full = fill_cnt == FULL;
  assign sample_shift = shift_en && state == IDLE;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      shift_en <= 1'b0;
      shift_data <= '0;
      fill_cnt <= '0;
      tap_valid <= 1'b0;
      flush_cnt <= '0;
    end else if (state == FLUSH) begin
      state <= flush_cnt == '0 ? IDLE : FLUSH;
      shift_en <= flush_cnt != '0;
      flush_cnt <= flush_cnt - CNT_W'(1);
      tap_valid <= 1'b0;
    end else if (flush_req) begin
      state <= FLUSH;
      shift_en <= 1'b1;
      shift_data <= '0;
      fill_cnt <= '0;
      tap_valid <= 1'b0;
      flush_cnt <= FULL - CNT_W'(1);
    end else begin
      shift_en <= s_valid;
      shift_data <= s_valid ? s_data : shift_data;
      fill_cnt <= fill_cnt + CNT_W'(sample_shift && !line_full);
      tap_valid <= sample_shift && fill_cnt >= FULL - CNT_W'(1);
    end
endmodule

// File: tb/tb_delay_line_sched.sv
// tb_delay_line_sched: randomized scoreboard bench for delay_line_sched against a behavioural line model
module tb_delay_line_sched;
  localparam int D = 8;
  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] s_data;
  logic s_valid;
  logic s_ready;
  logic flush_req;
  logic shift_en;
  logic [15:0] shift_data;
  logic [3:0] fill_cnt;
  logic line_full;
  logic tap_valid;
  logic busy;
  typedef struct {
    logic [15:0] d;
    logic f;
  } ent_t;
  ent_t sb[$];
  int errors = 0;
  int checks = 0;
  int m_fill, m_left, m_pend, m_tap;
  delay_line_sched #(.DATA_W(16), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .flush_req(flush_req), .shift_en(shift_en), .shift_data(shift_data), .fill_cnt(fill_cnt),
    .line_full(line_full), .tap_valid(tap_valid), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (rst_n === 1'b1 && shift_en === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow got shift_en=1 want no shift at %0t", $time);
      end else begin
        ent_t e;
        e = sb.pop_front();
        chk("shift_data", 32'(shift_data), 32'(e.d));
        chk("shift_busy", 32'(busy), 32'(e.f));
      end
    end
  task automatic cyc(input logic v, input logic [15:0] d, input logic f, input logic r);
    s_valid = v;
    s_data = d;
    flush_req = f;
    rst_n = r;
    #1;
    chk("s_ready", 32'(s_ready), 32'(m_left == 0 && !f));
    @(posedge clk);
    if (!r) begin
      sb.delete();
      m_fill = 0;
      m_left = 0;
      m_pend = 0;
      m_tap = 0;
    end else begin
      m_tap = 0;
      if (m_left > 0) m_left--;
      else if (f) begin
        m_left = D;
        m_fill = 0;
        m_pend = 0;
        for (int i = 0; i < D; i++) sb.push_back('{16'h0000, 1'b1});
      end else begin
        if (m_pend != 0) begin
          m_fill = m_fill < D ? m_fill + 1 : D;
          m_tap = m_fill == D ? 1 : 0;
        end
        m_pend = v ? 1 : 0;
        if (v) sb.push_back('{d, 1'b0});
      end
    end
    #1;
    chk("fill_cnt", 32'(fill_cnt), 32'(m_fill));
    chk("line_full", 32'(line_full), 32'(m_fill == D));
    chk("tap_valid", 32'(tap_valid), 32'(m_tap));
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("shift_en", 32'(shift_en), 32'(m_pend != 0 || m_left > 0));
    @(negedge clk);
  endtask
  initial begin
    int n;
    logic [1:0] pat[6];
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    flush_req = 1'b0;
    m_fill = 0;
    m_left = 0;
    m_pend = 0;
    m_tap = 0;
    @(negedge clk);
    @(negedge clk);
    cyc(0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) cyc(1, 16'(i), 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 16'hBEEF, 1, 1);
    n = 0;
    while (m_left > 0 && n < 20) begin
      cyc(1, 16'hBEEF, 0, 1);
      n++;
    end
    cyc(1, 16'hBEEF, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    pat = '{2'd1, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1};
    for (int i = 0; i < 6; i++) cyc(pat[i][0], 16'($urandom), 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) cyc(1, 16'($urandom), 1, 1);
    n = 0;
    while (m_left > 0 && n < 20) begin
      cyc(0, 0, 0, 1);
      n++;
    end
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 19) == 0,
          $urandom_range(0, 99) != 0);
    for (int i = 0; i < D + 2; i++) cyc(0, 0, 0, 1);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
